// File: rtl/pe_int_dot.sv
`default_nettype none
// ==========================================================================
// pe_int_dot : weight-stationary processing element, signed int dot product
// Revision   : 1.0
// ==========================================================================
module pe_int_dot #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int L_RAM_SIZE = 4,
  parameter int SAT        = 0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      ld_we,
  input  logic [L_RAM_SIZE-1:0]     ld_addr,
  input  logic signed [DATA_W-1:0]  ld_data,
  input  logic                      start,
  input  logic [L_RAM_SIZE:0]       len,
  input  logic signed [DATA_W-1:0]  ain,
  input  logic                      ain_valid,
  output logic                      ain_ready,
  output logic                      busy,
  output logic                      dvalid,
  output logic signed [ACC_W-1:0]   dout
);

  localparam int c_DEPTH = 2**L_RAM_SIZE;
  localparam int c_PW    = 2*DATA_W;
  localparam int c_SW    = ACC_W+1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [L_RAM_SIZE:0]    c_NMAX    = {1'b1, {L_RAM_SIZE{1'b0}}};
  localparam logic [L_RAM_SIZE:0]    c_ONE     = {{L_RAM_SIZE{1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]                r_state, w_state_nxt;
  logic signed [DATA_W-1:0]  r_ram [c_DEPTH];
  logic [L_RAM_SIZE:0]       r_n, r_idx, w_n;
  logic signed [DATA_W-1:0]  r_a, r_w;
  logic                      r_s1_vld, r_s2_vld;
  logic signed [c_PW-1:0]    r_prod;
  logic signed [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic signed [ACC_W:0]     w_sum;
  logic                      w_start_acc, w_beat, w_last, w_we;
  logic [L_RAM_SIZE-1:0]     w_addr;

  assign w_n         = (len > c_NMAX) ? c_NMAX : len;
  assign w_start_acc = (r_state == c_IDLE) && start;
  assign w_we        = (r_state == c_IDLE) && ld_we;
  assign w_beat      = ain_valid && ain_ready;
  assign w_last      = w_beat && (r_idx == r_n - c_ONE);
  // Single port: loads only happen in IDLE, reads only in RUN.
  assign w_addr      = w_we ? ld_addr : r_idx[L_RAM_SIZE-1:0];

  always_ff @(posedge aclk) begin : p_state
    if (!aresetn) r_state <= c_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_nxt = (w_n == '0) ? c_DONE : c_RUN;
      c_RUN:   if (w_last) w_state_nxt = c_DRAIN;
      // Stage 3 retires the final product on the same edge that leaves DRAIN.
      c_DRAIN: if (!r_s1_vld) w_state_nxt = c_DONE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin : p_out
    ain_ready = 1'b0;
    busy      = 1'b1;
    case (r_state)
      c_IDLE:  busy = 1'b0;
      c_RUN:   ain_ready = 1'b1;
      default: ;
    endcase
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge aclk) begin : p_ram
    if (w_we)   r_ram[w_addr] <= ld_data;
    if (w_beat) r_w <= r_ram[w_addr];
  end

  assign w_sum = c_SW'(r_acc) + c_SW'(r_prod);

  generate
    if (SAT != 0) begin : g_sat
      always_comb begin
        w_acc_nxt = w_sum[ACC_W-1:0];
        if (w_sum[ACC_W] != w_sum[ACC_W-1])
          w_acc_nxt = w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
      end
    end else begin : g_wrap
      assign w_acc_nxt = w_sum[ACC_W-1:0];
    end
  endgenerate

  always_ff @(posedge aclk) begin : p_dp
    if (!aresetn) begin
      r_n      <= '0;
      r_idx    <= '0;
      r_a      <= '0;
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_prod   <= '0;
      r_acc    <= '0;
      dvalid   <= 1'b0;
      dout     <= '0;
    end else begin
      r_s1_vld <= w_beat;
      r_s2_vld <= r_s1_vld;
      if (w_beat) begin
        r_a   <= ain;
        r_idx <= r_idx + c_ONE;
      end
      if (r_s1_vld) r_prod <= c_PW'(r_a) * c_PW'(r_w);
      if (w_start_acc) begin
        r_n   <= w_n;
        r_idx <= '0;
        r_acc <= '0;
      end else if (r_s2_vld) begin
        r_acc <= w_acc_nxt;
      end
      dvalid <= (r_state == c_DONE);
      if (r_state == c_DONE) dout <= r_acc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_int_dot.sv
`default_nettype none
// Scoreboard bench for pe_int_dot: three instances (32-bit wrap, 16-bit saturate,
// 16-bit wrap) share one stimulus stream; expected results come from a plain-integer model.
module tb_pe_int_dot;

  logic              aclk;
  logic              aresetn;
  logic              ld_we;
  logic [3:0]        ld_addr;
  logic signed [7:0] ld_data;
  logic              start;
  logic [4:0]        len;
  logic signed [7:0] ain;
  logic              ain_valid;

  logic ain_ready0, ain_ready1, ain_ready2;
  logic busy0, busy1, busy2;
  logic dvalid0, dvalid1, dvalid2;
  logic signed [31:0] dout0;
  logic signed [15:0] dout1, dout2;

  pe_int_dot #(.DATA_W(8), .ACC_W(32), .L_RAM_SIZE(4), .SAT(0)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .len(len), .ain(ain), .ain_valid(ain_valid), .ain_ready(ain_ready0),
    .busy(busy0), .dvalid(dvalid0), .dout(dout0));

  pe_int_dot #(.DATA_W(8), .ACC_W(16), .L_RAM_SIZE(4), .SAT(1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .len(len), .ain(ain), .ain_valid(ain_valid), .ain_ready(ain_ready1),
    .busy(busy1), .dvalid(dvalid1), .dout(dout1));

  pe_int_dot #(.DATA_W(8), .ACC_W(16), .L_RAM_SIZE(4), .SAT(0)) u_dut2 (
    .aclk(aclk), .aresetn(aresetn), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .len(len), .ain(ain), .ain_valid(ain_valid), .ain_ready(ain_ready2),
    .busy(busy2), .dvalid(dvalid2), .dout(dout2));

  typedef struct {
    longint v0;
    longint v1;
    longint v2;
    int     due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_due = 0;
  int   w[16];
  int   acts[16];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: sum of w[k]*a[k] over k<n, saturating per add or wrapping at the end.
  function automatic longint model(input int n, input int mode);
    longint s = 0;
    for (int k = 0; k < n; k++) begin
      s += longint'(w[k]) * longint'(acts[k]);
      if (mode == 1) begin
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
      end
    end
    if (mode == 0) return longint'(int'(s));
    if (mode == 2) return longint'(shortint'(s));
    return s;
  endfunction

  task automatic push_exp(input int n, input int due);
    exp_t e;
    e.v0 = model(n, 0);
    e.v1 = model(n, 1);
    e.v2 = model(n, 2);
    e.due = due;
    sbq.push_back(e);
    last_due = due;
  endtask

  // Monitor: every dvalid must match the oldest expected result and its cycle.
  always @(negedge aclk) begin
    if (dvalid0 || dvalid1 || dvalid2) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dvalid got=%0d%0d%0d exp=none (cycle %0d)",
                 dvalid0, dvalid1, dvalid2, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("dvalid_cycle", cyc, mon_e.due);
        chk("dvalid_all", {dvalid0, dvalid1, dvalid2}, 7);
        chk("dout_acc32_wrap", dout0, mon_e.v0);
        chk("dout_acc16_sat", dout1, mon_e.v1);
        chk("dout_acc16_wrap", dout2, mon_e.v2);
      end
    end
  end

  task automatic load_w();
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      ld_we = 1'b1;
      ld_addr = 4'(i);
      ld_data = 8'(w[i]);
    end
    @(negedge aclk);
    ld_we = 1'b0;
  endtask

  task automatic do_start(input int l, output int n);
    start = 1'b1;
    len = 5'(l);
    n = (l > 16) ? 16 : l;
    if (n == 0) push_exp(0, cyc + 2);
  endtask

  // mode 0: no gaps, 1: fixed valid pattern, 2: random gaps. Stops after 'stop' accepts.
  task automatic stream(input int n, input int mode, input int stop, input bit meddle,
                        output int rdy);
    int k = 0;
    int t = 0;
    bit v;
    int pat[7];
    pat = '{1, 0, 0, 1, 1, 0, 1};
    rdy = 0;
    while (k < stop && t < 400) begin
      @(negedge aclk);
      start = 1'b0;
      ld_we = 1'b0;
      case (mode)
        0:       v = 1'b1;
        1:       v = (t < 7) ? (pat[t] != 0) : 1'b1;
        default: v = ($urandom_range(3) != 0);
      endcase
      ain_valid = v;
      ain = v ? 8'(acts[k]) : 8'($urandom);
      if (meddle && k == 1) begin
        ld_we = 1'b1;
        ld_addr = 4'd0;
        ld_data = 8'sd99;
        start = 1'b1;
        len = 5'd3;
      end
      if (ain_ready0) rdy++;
      if (v && ain_ready0) begin
        k++;
        if (k == n) push_exp(n, cyc + 4);
      end
      t++;
    end
    if (k < stop) chk("stream_timeout_beats", k, stop);
  endtask

  task automatic tail(input int cycles, output int extra);
    extra = 0;
    repeat (cycles) begin
      @(negedge aclk);
      start = 1'b0;
      ld_we = 1'b0;
      ain_valid = 1'b1;
      ain = 8'($urandom);
      if (ain_ready0) extra++;
    end
    ain_valid = 1'b0;
  endtask

  task automatic wait_due();
    int g = 0;
    while (cyc < last_due && g < 100) begin
      @(negedge aclk);
      g++;
    end
    chk("busy_low_at_dvalid", busy0, 0);
  endtask

  task automatic run(input int l, input int mode, input bit meddle);
    int n, rdy, extra;
    do_start(l, n);
    stream(n, mode, n, meddle, rdy);
    tail((n == 0) ? 1 : 3, extra);
    if (mode == 0) chk("ready_cycles", rdy, n);
    else if (mode == 1) chk("ready_cycles_pattern", rdy, 7);
    chk("extra_beats_after_last", extra, 0);
    wait_due();
  endtask

  task automatic rand_w();
    for (int i = 0; i < 16; i++) w[i] = int'($urandom_range(255)) - 128;
  endtask

  task automatic rand_acts();
    for (int i = 0; i < 16; i++) acts[i] = int'($urandom_range(255)) - 128;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rdy;
    aresetn = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; len = '0; ain = '0; ain_valid = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    chk("reset_busy", {busy0, busy1, busy2}, 0);
    chk("reset_ain_ready", {ain_ready0, ain_ready1, ain_ready2}, 0);
    chk("reset_dvalid", {dvalid0, dvalid1, dvalid2}, 0);
    chk("reset_dout32", dout0, 0);
    chk("reset_dout16", {dout1, dout2}, 0);

    // Basic vector, no gaps, then the same with a sparse valid pattern.
    rand_w();
    w[0] = 1; w[1] = 2; w[2] = 3; w[3] = 4;
    load_w();
    acts[0] = 5; acts[1] = 6; acts[2] = 7; acts[3] = 8;
    chk("model_basic_dot", model(4, 0), 70);
    run(4, 0, 1'b0);
    run(4, 1, 1'b0);

    // Extreme values: 16 x (-128 * -128), then len above depth clamps to 16.
    for (int i = 0; i < 16; i++) begin w[i] = -128; acts[i] = -128; end
    load_w();
    run(16, 0, 1'b0);
    rand_acts();
    run(31, 0, 1'b0);

    // Zero-length start.
    run(0, 0, 1'b0);

    // Reset mid-run: no result, then rerun with the retained RAM.
    rand_w();
    load_w();
    rand_acts();
    do_start(4, n);
    stream(4, 0, 2, 1'b0, rdy);
    @(negedge aclk);
    ain_valid = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    chk("abort_busy", busy0, 0);
    chk("abort_ain_ready", ain_ready0, 0);
    chk("abort_dout", dout0, 0);
    repeat (6) @(negedge aclk);
    rand_acts();
    run(4, 2, 1'b0);

    // Load and start attempts during RUN are ignored; back-to-back starts.
    rand_acts();
    run(5, 2, 1'b1);
    rand_acts();
    run(int'($urandom_range(1, 16)), 2, 1'b0);
    rand_acts();
    run(16, 0, 1'b0);

    // Randomised lengths, weights and gaps.
    for (int it = 0; it < 8; it++) begin
      if (it % 2 == 0) begin
        rand_w();
        load_w();
      end
      rand_acts();
      run(int'($urandom_range(31)), 2, 1'b0);
    end

    repeat (8) @(negedge aclk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
